// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the rotate-priority pick used by the FIFO write/read arbiters.
// Supports up to MAX_REQ requesters.
package fifo_arb_pkg;

    localparam int MAX_REQ       = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic {IDLE, BURST} arb_state_t;

    typedef struct packed {
        logic       any;
        logic [2:0] idx;
    } pick_t;

    // First set bit scanning upward from ptr, wrapping at n (n need not be a power of two).
    function automatic pick_t rotate_pick(input logic [MAX_REQ-1:0] req,
                                          input int unsigned n,
                                          input int unsigned ptr);
        pick_t       p;
        int unsigned j;
        p.any = 1'b0;
        p.idx = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (k < n && !p.any && req[j]) begin
                p.any = 1'b1;
                p.idx = 3'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side handshake bundle of the write arbiter.
// slave = arbiter, master = producers plus the FIFO full flag.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifoFull;
    logic                      wrEn;
    logic [DATA_W-1:0]         din;

    modport master (
        output req_valid, req_data, req_last, fifoFull,
        input  req_ready, wrEn, din
    );

    modport slave (
        input  req_valid, req_data, req_last, fifoFull,
        output req_ready, wrEn, din
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest set request at or above ptr, wrapping.
// Zero latency; no state, no backpressure.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);
    pick_t p;

    assign p   = rotate_pick(MAX_REQ'(req), NUM_REQ, 32'(ptr));
    assign any = p.any;
    assign idx = IDX_W'(p.idx);
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited scheduler sharing one FIFO write port among NUM_REQ producers.
// 1-cycle arbitration, then zero-latency valid->write; fifoFull stalls the grant in place.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                 wrClk,
    input  logic                 rst,
    fifo_wr_arbiter_if.slave     bus,
    output logic [IDX_W-1:0]     gnt_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     wr_count
);
    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [3:0]         beat_cnt;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               xfer;
    logic               last_beat;
    logic [IDX_W-1:0]   nxt_ptr;
    logic [NUM_REQ-1:0] ready;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign xfer      = (state == BURST) && bus.req_valid[gnt_id] && !bus.fifoFull;
    assign last_beat = bus.req_last[gnt_id] || (beat_cnt == 4'(MAX_BURST - 1));
    assign nxt_ptr   = (gnt_id == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_comb begin
        ready = '0;
        if (xfer) ready[gnt_id] = 1'b1;
    end

    assign bus.req_ready = ready;
    assign bus.wrEn      = xfer;
    assign bus.din       = xfer ? bus.req_data[gnt_id*DATA_W +: DATA_W] : '0;
    assign busy          = (state == BURST);

    always_ff @(posedge wrClk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_id   <= '0;
            beat_cnt <= '0;
            wr_count <= '0;
        end else begin
            if (xfer) wr_count <= wr_count + 1'b1;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_id   <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= nxt_ptr;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end else if (!bus.req_valid[gnt_id]) begin
                        // Producer went idle: release so the others are not starved.
                        state  <= IDLE;
                        rr_ptr <= nxt_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4, CNT_W=16).
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  gnt_id;
    logic        busy;
    logic [15:0] wr_count;
    int          n_chk = 0;
    int          n_err = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4), .CNT_W(16)) dut (
        .wrClk    (clk),
        .rst      (rst),
        .bus      (bus),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled mid-cycle, well clear of either edge.
    task automatic settle();
        #2;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.req_data[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifoFull  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset then idle
        do_reset();
        rst = 1'b0;
        settle();
        chk("rst_wrEn", 32'(bus.wrEn), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_din", 32'(bus.din), 0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            settle();
            chk("idle_wrEn", 32'(bus.wrEn), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_cnt", 32'(wr_count), 0);
            chk("idle_gnt", 32'(gnt_id), 0);
        end

        // Single producer packet: req 1 sends A1,A2,A3
        do_reset();
        tick();
        bus.req_valid = 4'b0010;
        set_data(1, 8'hA1);
        settle();
        chk("sp_arb_busy", 32'(busy), 0);
        chk("sp_arb_wrEn", 32'(bus.wrEn), 0);
        tick();
        settle();
        chk("sp_b0_busy", 32'(busy), 1);
        chk("sp_b0_din", 32'(bus.din), 32'hA1);
        chk("sp_b0_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        set_data(1, 8'hA2);
        settle();
        chk("sp_b1_din", 32'(bus.din), 32'hA2);
        chk("sp_b1_wrEn", 32'(bus.wrEn), 1);
        tick();
        set_data(1, 8'hA3);
        bus.req_last = 4'b0010;
        settle();
        chk("sp_b2_din", 32'(bus.din), 32'hA3);
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        settle();
        chk("sp_end_busy", 32'(busy), 0);
        chk("sp_end_wrEn", 32'(bus.wrEn), 0);
        chk("sp_end_cnt", 32'(wr_count), 3);

        // Round-robin fairness: all four continuously valid
        do_reset();
        tick();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'hC0 + i));
        for (int g = 0; g < 5; g++) begin
            settle();
            chk("rr_gap_wrEn", 32'(bus.wrEn), 0);
            chk("rr_gap_busy", 32'(busy), 0);
            tick();
            for (int b = 0; b < 4; b++) begin
                settle();
                chk("rr_gnt", 32'(gnt_id), 32'(g % 4));
                chk("rr_wrEn", 32'(bus.wrEn), 1);
                chk("rr_din", 32'(bus.din), 32'(8'hC0 + (g % 4)));
                chk("rr_ready", 32'(bus.req_ready), 32'(1 << (g % 4)));
                tick();
            end
        end
        bus.req_valid = '0;
        settle();
        chk("rr_cnt", 32'(wr_count), 20);

        // Backpressure: fifoFull for 5 cycles at beat 2 of req 2
        do_reset();
        tick();
        bus.req_valid = 4'b0100;
        set_data(2, 8'h20);
        tick();
        settle();
        chk("bp_b0_din", 32'(bus.din), 32'h20);
        tick();
        set_data(2, 8'h21);
        settle();
        chk("bp_b1_din", 32'(bus.din), 32'h21);
        tick();
        set_data(2, 8'h22);
        bus.fifoFull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_stall_wrEn", 32'(bus.wrEn), 0);
            chk("bp_stall_ready", 32'(bus.req_ready), 0);
            chk("bp_stall_busy", 32'(busy), 1);
            tick();
        end
        bus.fifoFull = 1'b0;
        settle();
        chk("bp_b2_din", 32'(bus.din), 32'h22);
        chk("bp_b2_wrEn", 32'(bus.wrEn), 1);
        tick();
        set_data(2, 8'h23);
        settle();
        chk("bp_b3_din", 32'(bus.din), 32'h23);
        tick();
        bus.req_valid = '0;
        settle();
        chk("bp_end_busy", 32'(busy), 0);
        chk("bp_end_cnt", 32'(wr_count), 4);

        // Producer abandons: req 3 drops valid after one beat, req 0 waiting
        do_reset();
        tick();
        bus.req_valid = 4'b1000;
        set_data(3, 8'h33);
        set_data(0, 8'h50);
        tick();
        bus.req_valid = 4'b1001;
        settle();
        chk("ab_gnt3", 32'(gnt_id), 3);
        chk("ab_b0_din", 32'(bus.din), 32'h33);
        tick();
        bus.req_valid = 4'b0001;
        settle();
        chk("ab_drop_wrEn", 32'(bus.wrEn), 0);
        chk("ab_drop_busy", 32'(busy), 1);
        tick();
        settle();
        chk("ab_idle_busy", 32'(busy), 0);
        tick();
        settle();
        chk("ab_gnt0", 32'(gnt_id), 0);
        chk("ab_gnt0_din", 32'(bus.din), 32'h50);
        chk("ab_gnt0_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = '0;
        settle();
        chk("ab_cnt", 32'(wr_count), 2);

        // Async reset mid-burst
        do_reset();
        tick();
        bus.req_valid = 4'b0010;
        set_data(1, 8'h77);
        tick();
        tick();
        settle();
        chk("ar_pre_wrEn", 32'(bus.wrEn), 1);
        chk("ar_pre_cnt", 32'(wr_count), 1);
        rst = 1'b0;
        #1;
        chk("ar_wrEn", 32'(bus.wrEn), 0);
        chk("ar_ready", 32'(bus.req_ready), 0);
        chk("ar_din", 32'(bus.din), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_cnt", 32'(wr_count), 0);
        chk("ar_gnt", 32'(gnt_id), 0);
        tick();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        settle();
        chk("ar_after_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
